// File: rtl/dense_1_feeder.sv
// dense_1_feeder
//   Rate-matching packer in front of the first dense layer of the modulation
//   classifier. Narrow feature beats are packed MSB-first into wide words,
//   queued in a small FIFO and released as single-cycle pulses spaced at
//   least GAP cycles apart, so the 2-bit-per-cycle serial consumer downstream
//   never sees a word before it has finished with the previous one. The last
//   word of each classification frame is tagged with last_out.
//
// Ports
//   clk       clock
//   rst       synchronous, active-high reset
//   vld_in    input beat valid
//   data_in   input beat (IN_W bits)
//   rdy_out   block can accept a beat this cycle
//   vld_out   one-cycle pulse: data_out holds a new packed word
//   data_out  packed word (OUT_W bits), held until the next pulse
//   last_out  qualifies vld_out; marks the final word of a frame
//   ovf       sticky flag: a beat was offered while rdy_out was low
module dense_1_feeder #(
  parameter int IN_W            = 32,
  parameter int OUT_W           = 128,
  parameter int WORDS_PER_FRAME = 8,
  parameter int GAP             = 64,
  parameter int DEPTH           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_in,
  input  logic [IN_W-1:0]  data_in,
  output logic             rdy_out,
  output logic             vld_out,
  output logic [OUT_W-1:0] data_out,
  output logic             last_out,
  output logic             ovf
);

  localparam int PACK    = OUT_W / IN_W;
  localparam int PACK_W  = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int FRAME_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
  localparam int GAP_W   = $clog2(GAP);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic [PACK_W-1:0]  pack_cnt;
  logic [OUT_W-1:0]   pack_word;
  logic [FRAME_W-1:0] frame_idx;
  logic [GAP_W-1:0]   gap_cnt;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_count;

  logic [OUT_W-1:0]   mem_word [DEPTH];
  logic               mem_last [DEPTH];

  logic               accept;
  logic               push;
  logic               pop;
  logic               word_last;
  logic [OUT_W-1:0]   packed_next;

  // The full check is on the FIFO alone; the word being assembled does not
  // need a slot until its final beat, and that beat is refused when full.
  assign rdy_out = !rst && (fifo_count < CNT_W'(DEPTH));
  assign accept  = vld_in && rdy_out;
  assign push    = accept && (pack_cnt == PACK_W'(PACK - 1));
  assign pop     = (fifo_count != '0) && (gap_cnt == '0);

  // Shifting left as beats arrive leaves the earliest beat in the MSBs once
  // the word is complete, which is the order the serialiser consumes.
  assign packed_next = (pack_word << IN_W) | OUT_W'(data_in);
  assign word_last   = (frame_idx == FRAME_W'(WORDS_PER_FRAME - 1));

  // FIFO storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_word[wr_ptr] <= packed_next;
      mem_last[wr_ptr] <= word_last;
    end
  end

  // Packing, frame tracking, FIFO bookkeeping, pulse spacing and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pack_cnt   <= '0;
      pack_word  <= '0;
      frame_idx  <= '0;
      gap_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      vld_out    <= 1'b0;
      data_out   <= '0;
      last_out   <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      if (vld_in && !rdy_out) begin
        ovf <= 1'b1;
      end

      if (accept) begin
        pack_word <= packed_next;
        if (pack_cnt == PACK_W'(PACK - 1)) begin
          pack_cnt <= '0;
        end else begin
          pack_cnt <= pack_cnt + 1'b1;
        end
      end

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (word_last) begin
          frame_idx <= '0;
        end else begin
          frame_idx <= frame_idx + 1'b1;
        end
      end

      // A push and a pop in the same cycle leave the occupancy unchanged.
      if (push && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (pop && !push) begin
        fifo_count <= fifo_count - 1'b1;
      end

      // Loading GAP-1 on a pop makes the next pop land exactly GAP cycles
      // later; with an empty FIFO the counter parks at zero so a freshly
      // pushed word goes out on the very next cycle.
      if (pop) begin
        gap_cnt <= GAP_W'(GAP - 1);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end

      vld_out <= pop;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem_word[rd_ptr];
        last_out <= mem_last[rd_ptr];
      end else begin
        last_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dense_1_feeder.sv
// tb_dense_1_feeder
//   Self-checking bench for dense_1_feeder. A queue-based reference model
//   collects accepted beats, forms packed words, and releases them no sooner
//   than GAP cycles after the previous release; every cycle the DUT outputs
//   are compared with the model's prediction. Directed phases exercise the
//   single frame, frame wrap, back-pressure/overflow, sparse input, reset
//   mid-word and coincident push/pop cases, followed by a random phase.
module tb_dense_1_feeder;

  localparam int IN_W  = 32;
  localparam int OUT_W = 128;
  localparam int WPF   = 8;
  localparam int GAP   = 64;
  localparam int DEPTH = 16;
  localparam int PACK  = OUT_W / IN_W;

  logic             clk;
  logic             rst;
  logic             vld_in;
  logic [IN_W-1:0]  data_in;
  logic             rdy_out;
  logic             vld_out;
  logic [OUT_W-1:0] data_out;
  logic             last_out;
  logic             ovf;

  dense_1_feeder #(
    .IN_W(IN_W), .OUT_W(OUT_W), .WORDS_PER_FRAME(WPF), .GAP(GAP), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .data_in(data_in),
    .rdy_out(rdy_out), .vld_out(vld_out), .data_out(data_out),
    .last_out(last_out), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [IN_W-1:0]  m_part[$];
  logic [OUT_W-1:0] m_word_q[$];
  bit               m_last_q[$];
  int               m_words_made = 0;
  int               m_last_pop = -GAP;
  bit               exp_vld = 0;
  logic [OUT_W-1:0] exp_data = '0;
  bit               exp_last = 0;
  bit               exp_ovf = 0;

  // Observation records, cleared at each reset
  int               cyc = 0;
  bit               check_en = 0;
  int               prev_pulse = -1;
  int               obs_cyc[$];
  logic [OUT_W-1:0] obs_data[$];
  bit               obs_last[$];
  int               acc_cyc[$];
  bit               saw_rdy_low = 0;

  task automatic checkOutput(input string tag, input logic [OUT_W-1:0] obs,
                             input logic [OUT_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: compare, advance the model with this cycle's inputs.
  task automatic tick();
    bit m_rdy;
    logic [OUT_W-1:0] w;
    @(negedge clk);
    m_rdy = !rst && (m_word_q.size() < DEPTH);
    if (check_en) begin
      checkOutput("vld_out", OUT_W'(vld_out), OUT_W'(exp_vld));
      checkOutput("data_out", data_out, exp_data);
      checkOutput("last_out", OUT_W'(last_out), OUT_W'(exp_last));
      checkOutput("ovf", OUT_W'(ovf), OUT_W'(exp_ovf));
      checkOutput("rdy_out", OUT_W'(rdy_out), OUT_W'(m_rdy));
      if (vld_out === 1'b1) begin
        if (prev_pulse >= 0)
          checkOutput("spacing_ge_gap", OUT_W'((cyc - prev_pulse) >= GAP), OUT_W'(1));
        prev_pulse = cyc;
        obs_cyc.push_back(cyc);
        obs_data.push_back(data_out);
        obs_last.push_back(last_out);
      end
      if (!rst && rdy_out === 1'b0) saw_rdy_low = 1;
    end
    if (rst) begin
      m_part.delete();
      m_word_q.delete();
      m_last_q.delete();
      m_words_made = 0;
      m_last_pop = cyc - GAP;
      exp_vld = 0;
      exp_data = '0;
      exp_last = 0;
      exp_ovf = 0;
      prev_pulse = -1;
    end else begin
      if (m_word_q.size() > 0 && (cyc - m_last_pop) >= GAP) begin
        exp_vld = 1;
        exp_data = m_word_q.pop_front();
        exp_last = m_last_q.pop_front();
        m_last_pop = cyc;
      end else begin
        exp_vld = 0;
        exp_last = 0;
      end
      if (vld_in && !m_rdy) exp_ovf = 1;
      if (vld_in && m_rdy) begin
        acc_cyc.push_back(cyc);
        m_part.push_back(data_in);
        if (m_part.size() == PACK) begin
          w = '0;
          foreach (m_part[i]) w = (w << IN_W) | OUT_W'(m_part[i]);
          m_word_q.push_back(w);
          m_last_q.push_back((m_words_made % WPF) == WPF - 1);
          m_words_made++;
          m_part.delete();
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [IN_W-1:0] d);
    rst = r;
    vld_in = v;
    data_in = d;
    tick();
  endtask

  task automatic clearRecords();
    obs_cyc.delete();
    obs_data.delete();
    obs_last.delete();
    acc_cyc.delete();
    saw_rdy_low = 0;
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
    clearRecords();
  endtask

  task automatic waitPulses(input int n, input int budget);
    int k = 0;
    while (obs_cyc.size() < n && k < budget) begin
      applyStimulus(1'b0, 1'b0, '0);
      k++;
    end
  endtask

  initial begin
    logic [IN_W-1:0] beat;
    logic [IN_W-1:0] b[4];
    logic [OUT_W-1:0] word_b;
    logic [OUT_W-1:0] word_c;
    int k;
    int density;
    int n_last;

    rst = 1'b1;
    vld_in = 1'b0;
    data_in = '0;
    applyStimulus(1'b1, 1'b0, '0);
    check_en = 1;
    doReset();

    // Reset values
    checkOutput("reset_vld", OUT_W'(vld_out), '0);
    checkOutput("reset_data", data_out, '0);
    checkOutput("reset_ovf", OUT_W'(ovf), '0);
    checkOutput("rdy_in_reset", OUT_W'(rdy_out), '0);

    // Single frame: beat k replicates nibble k
    for (int i = 0; i < 32; i++) begin
      beat = {8{4'(i)}};
      applyStimulus(1'b0, 1'b1, beat);
    end
    waitPulses(8, 1000);
    checkOutput("frame_pulses", OUT_W'(obs_cyc.size()), OUT_W'(8));
    if (obs_cyc.size() >= 8 && acc_cyc.size() >= 4) begin
      checkOutput("first_latency", OUT_W'(obs_cyc[0] - acc_cyc[3]), OUT_W'(2));
      checkOutput("word0", obs_data[0], 128'h00000000_11111111_22222222_33333333);
      for (int i = 1; i < 8; i++)
        checkOutput("frame_spacing", OUT_W'(obs_cyc[i] - obs_cyc[i-1]), OUT_W'(GAP));
      for (int i = 0; i < 8; i++)
        checkOutput("frame_last", OUT_W'(obs_last[i]), OUT_W'(i == 7));
    end

    // Frame wrap: 64 continuous beats
    doReset();
    for (int i = 0; i < 64; i++) applyStimulus(1'b0, 1'b1, $urandom);
    waitPulses(16, 2000);
    checkOutput("wrap_pulses", OUT_W'(obs_cyc.size()), OUT_W'(16));
    if (obs_cyc.size() >= 16)
      for (int i = 0; i < 16; i++)
        checkOutput("wrap_last", OUT_W'(obs_last[i]), OUT_W'(i == 7 || i == 15));

    // Back-pressure: 100 beats offered only while the model says ready
    doReset();
    k = 0;
    while (acc_cyc.size() < 100 && k < 5000) begin
      if (m_word_q.size() < DEPTH) applyStimulus(1'b0, 1'b1, $urandom);
      else applyStimulus(1'b0, 1'b0, '0);
      k++;
    end
    checkOutput("bp_beats", OUT_W'(acc_cyc.size()), OUT_W'(100));
    checkOutput("bp_rdy_fell", OUT_W'(saw_rdy_low), OUT_W'(1));
    checkOutput("bp_ovf_clear", OUT_W'(ovf), '0);
    k = 0;
    while (!exp_ovf && k < 2000) begin
      applyStimulus(1'b0, 1'b1, $urandom);
      k++;
    end
    checkOutput("ovf_set", OUT_W'(ovf), OUT_W'(1));
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("ovf_sticky", OUT_W'(ovf), OUT_W'(1));
    doReset();
    checkOutput("ovf_cleared", OUT_W'(ovf), '0);

    // Sparse input: one beat every 100 cycles
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, $urandom);
      for (int j = 0; j < 99; j++) applyStimulus(1'b0, 1'b0, '0);
    end
    waitPulses(2, 200);
    checkOutput("sparse_pulses", OUT_W'(obs_cyc.size()), OUT_W'(2));
    if (obs_cyc.size() >= 2 && acc_cyc.size() >= 8) begin
      checkOutput("sparse_lat0", OUT_W'(obs_cyc[0] - acc_cyc[3]), OUT_W'(2));
      checkOutput("sparse_lat1", OUT_W'(obs_cyc[1] - acc_cyc[7]), OUT_W'(2));
    end

    // Reset mid-word
    doReset();
    applyStimulus(1'b0, 1'b1, 32'hDEAD0001);
    applyStimulus(1'b0, 1'b1, 32'hDEAD0002);
    applyStimulus(1'b1, 1'b0, '0);
    clearRecords();
    for (int i = 0; i < 32; i++) begin
      beat = $urandom;
      if (i < 4) b[i] = beat;
      applyStimulus(1'b0, 1'b1, beat);
    end
    waitPulses(8, 1000);
    checkOutput("midrst_pulses", OUT_W'(obs_cyc.size()), OUT_W'(8));
    if (obs_cyc.size() >= 8) begin
      checkOutput("midrst_word0", obs_data[0], {b[0], b[1], b[2], b[3]});
      n_last = 0;
      for (int i = 0; i < 8; i++) n_last += obs_last[i];
      checkOutput("midrst_last_count", OUT_W'(n_last), OUT_W'(1));
      checkOutput("midrst_last8", OUT_W'(obs_last[7]), OUT_W'(1));
    end

    // Push and pop in the same cycle with one word queued
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, $urandom);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      b[i] = $urandom;
      applyStimulus(1'b0, 1'b1, b[i]);
    end
    word_b = {b[0], b[1], b[2], b[3]};
    k = 0;
    while ((cyc - m_last_pop) != GAP - 3 && k < 200) begin
      applyStimulus(1'b0, 1'b0, '0);
      k++;
    end
    for (int i = 0; i < 4; i++) begin
      b[i] = $urandom;
      applyStimulus(1'b0, 1'b1, b[i]);
    end
    word_c = {b[0], b[1], b[2], b[3]};
    waitPulses(3, 400);
    for (int i = 0; i < 200; i++) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("pp_pulses", OUT_W'(obs_cyc.size()), OUT_W'(3));
    if (obs_cyc.size() >= 3) begin
      checkOutput("pp_word_b", obs_data[1], word_b);
      checkOutput("pp_word_c", obs_data[2], word_c);
      checkOutput("pp_spacing", OUT_W'(obs_cyc[2] - obs_cyc[1]), OUT_W'(GAP));
    end

    // Random traffic with varying density and occasional reset
    doReset();
    for (int seg = 0; seg < 6; seg++) begin
      density = $urandom_range(1, 4);
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 999) == 0)
          applyStimulus(1'b1, 1'b0, '0);
        else
          applyStimulus(1'b0, $urandom_range(0, 3) < density, $urandom);
      end
    end

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dense_1_feeder.md
Name: dense_1_feeder

Overview:
- Upstream rate-matching packer for the first dense layer of the modulation classifier.
- Accepts narrow flattened feature words from the last conv/pool stage and packs them into 128-bit words.
- Buffers packed words in a FIFO and releases them as single-cycle pulses spaced at least GAP cycles apart, matching the dense stage's 2-bit-per-cycle serial consumption (64 cycles per 128-bit word, 8 words per frame).
- Tags the last word of each frame.

Parameters:
- IN_W, 32: input word width; must divide OUT_W.
- OUT_W, 128: packed output word width.
- WORDS_PER_FRAME, 8: packed words per classification frame.
- GAP, 64: minimum cycles between successive vld_out pulses; must be ≥ 2.
- DEPTH, 16: FIFO depth in packed words; power of 2.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- vld_in, input, 1: input beat valid.
- data_in, input, IN_W: input beat.
- rdy_out, output, 1: block can accept a beat this cycle.
- vld_out, output, 1: one-cycle pulse; data_out is a new packed word.
- data_out, output, OUT_W: packed word; held until the next pulse.
- last_out, output, 1: qualifies vld_out; marks word WORDS_PER_FRAME-1 of the frame.
- ovf, output, 1: sticky; a beat was offered while rdy_out=0.

Behaviour:
- Interface: clock clk; reset rst, synchronous, active-high.
- Reset values: vld_out=0, data_out=0, last_out=0, ovf=0. Pack counter, frame word index, FIFO pointers/count and gap counter all cleared. rdy_out=0 while rst=1.
- Reset mid-operation discards any partial pack and all FIFO contents. The first beat after reset starts a new word at index 0 of a new frame.
- Accept: a beat is accepted when vld_in && rdy_out.
- rdy_out = (fifo_count < DEPTH), combinational from registered state.
- A beat offered with rdy_out=0 is dropped and sets ovf; ovf is cleared only by rst.
- Packing order: the first accepted beat of a word occupies data_out[OUT_W-1 -: IN_W]; later beats fill toward the LSBs, so the earliest data is consumed first by the MSB-first serialiser.
- PACK = OUT_W/IN_W beats per word. The pack counter runs 0..PACK-1 and wraps.
- On the PACK-th beat, the completed word is written to the FIFO at that clock edge, together with a last flag = (frame_idx == WORDS_PER_FRAME-1).
- frame_idx increments per completed word and wraps to 0 after WORDS_PER_FRAME-1.
- Because the full check compares fifo_count < DEPTH, the partially packed word never overflows the FIFO.
- Issue: in cycle t, if the FIFO is non-empty and gap_cnt == 0, pop the head word. Registers update at the edge ending cycle t, so vld_out=1 with the head data and last flag in cycle t+1. gap_cnt loads GAP-1 and decrements to 0.
- Spacing: consecutive vld_out pulses are exactly GAP cycles apart while the FIFO stays non-empty, and never fewer than GAP.
- Latency: if the final beat of a word is accepted in cycle t, the FIFO is empty and gap_cnt == 0, then vld_out=1 in cycle t+2.
- Simultaneous push and pop: allowed in the same cycle; count is unchanged. A push into a full FIFO is impossible because the beat is not accepted.
- Empty FIFO: no pulse is issued; gap_cnt keeps decrementing to 0 and holds there.
- Arithmetic: pure bit packing, no sign handling. Counters are $clog2-sized; the FIFO count is $clog2(DEPTH)+1 bits.

Test Plan:
- Single frame: 32 beats, beat k = {8{k[3:0]}}, continuous vld_in after reset.
  - 8 vld_out pulses; the first 2 cycles after the 4th beat, then every 64 cycles.
  - word0 = 0x00000000_11111111_22222222_33333333 (each beat replicates nibble k, so beat 1 gives 0x11111111).
  - last_out only on pulse 8.
- Back-pressure: 100 beats with no gaps.
  - rdy_out falls once fifo_count = 16; ovf stays 0 while vld_in is dropped on rdy_out=0.
  - Force vld_in=1 with rdy_out=0: ovf=1 permanently until rst.
- Sparse input: one beat every 100 cycles.
  - Each vld_out follows its 4th beat by 2 cycles; spacing ≥ 64; data_out is held between pulses.
- Reset mid-word: 2 beats, rst for 1 cycle, then 4 beats (A,B,C,D).
  - First word = {A,B,C,D}; pre-reset beats are absent; last_out appears on the 8th word after reset.
- Frame wrap: 64 continuous beats.
  - last_out on pulses 8 and 16 only; word 9 starts at frame index 0.
- Simultaneous push/pop: time a word completion on the same cycle as a pop with FIFO count 1.
  - Count stays 1; no lost or duplicated word; order is preserved.
